// File: rtl/phy_bringup_pkg.sv
// Shared definitions for the PHY bring-up sequencer: channel state encoding,
// strap field layout and counter sizing helpers.
package phy_bringup_pkg;

    // Per-channel sequencing states.
    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,  // gated off, waiting for the previous channel
        ST_RESET  = 3'd1,  // hw reset asserted, strap latch tracking strap_val
        ST_STRAP  = 3'd2,  // hw reset released, straps still driven and frozen
        ST_SETTLE = 3'd3,  // straps released, waiting for the PHY to settle
        ST_READY  = 3'd4   // channel configured, downstream logic may run
    } ch_state_t;

    // Strap word layout: {addr[4:0], rx_dv, rxd[7:0]}.
    localparam int RXD_LSB   = 0;
    localparam int RXD_W     = 8;
    localparam int RX_DV_BIT = 8;
    localparam int ADDR_LSB  = 9;
    localparam int ADDR_W    = 5;

    // Width of a counter able to hold the largest of the three durations.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    // True when a strap word of the given width matches the field layout above.
    function automatic bit strap_layout_ok(input int strap_w);
        return (RXD_LSB == 0)
            && (RX_DV_BIT == RXD_LSB + RXD_W)
            && (ADDR_LSB == RX_DV_BIT + 1)
            && (strap_w == ADDR_LSB + ADDR_W);
    endfunction

endpackage

// File: rtl/phy_bringup_ch.sv
// One PHY channel: sequencing FSM, shared duration counter and strap latch.
// All outputs are registered from the next-state decode so they change only
// on a clk_50 edge and carry no combinational path from gate/reinit.
module phy_bringup_ch
    import phy_bringup_pkg::*;
#(
    parameter int STRAP_W        = 14,
    parameter int RST_HOLD_CYC   = 500000,
    parameter int STRAP_HOLD_CYC = 50,
    parameter int SETTLE_CYC     = 250000
) (
    input  logic               clk_50,
    input  logic               reset_n,
    input  logic               gate,
    input  logic               reinit,
    input  logic [STRAP_W-1:0] strap_in,
    output logic [STRAP_W-1:0] strap_out,
    output logic               strap_oe,
    output logic               hw_rst,
    output logic               ready
);

    localparam int CNT_W = cnt_width(RST_HOLD_CYC, STRAP_HOLD_CYC, SETTLE_CYC);

    // Terminal counts: a state lasting N cycles leaves when the counter,
    // cleared on entry, reaches N-1.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STRAP_LAST  = CNT_W'(STRAP_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    ch_state_t        state;
    ch_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             restart;
    logic             load_strap;
    logic             hw_rst_nxt;
    logic             oe_nxt;
    logic             ready_nxt;

    // A restart request only counts once the channel has left WAIT.
    assign restart = reinit && (state != ST_WAIT);

    // The latch follows strap_val while the PHY is held in reset and freezes
    // from the first STRAP cycle, so the PHY samples a stable value.
    assign load_strap = (state == ST_WAIT) || (state == ST_RESET);

    // Next-state and counter: normal sequencing, then restart overrides it.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;

        case (state)
            ST_WAIT:   if (gate)                state_nxt = ST_RESET;
            ST_RESET:  if (cnt == RST_LAST)     state_nxt = ST_STRAP;
            ST_STRAP:  if (cnt == STRAP_LAST)   state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt == SETTLE_LAST)  state_nxt = ST_READY;
            ST_READY:                           state_nxt = ST_READY;
            default:                            state_nxt = ST_WAIT;
        endcase

        if (restart) begin
            state_nxt = ST_RESET;
        end

        // The counter restarts on every state entry (including RESET -> RESET
        // on a held request) and idles at zero where nothing is timed.
        if (restart || (state_nxt != state) ||
            (state == ST_WAIT) || (state == ST_READY)) begin
            cnt_nxt = '0;
        end
    end

    // Output decode of the state being entered, registered below.
    always_comb begin
        hw_rst_nxt = 1'b0;
        oe_nxt     = 1'b1;
        ready_nxt  = 1'b0;
        case (state_nxt)
            ST_WAIT:   begin hw_rst_nxt = 1'b0; oe_nxt = 1'b1; ready_nxt = 1'b0; end
            ST_RESET:  begin hw_rst_nxt = 1'b0; oe_nxt = 1'b1; ready_nxt = 1'b0; end
            ST_STRAP:  begin hw_rst_nxt = 1'b1; oe_nxt = 1'b1; ready_nxt = 1'b0; end
            ST_SETTLE: begin hw_rst_nxt = 1'b1; oe_nxt = 1'b0; ready_nxt = 1'b0; end
            ST_READY:  begin hw_rst_nxt = 1'b1; oe_nxt = 1'b0; ready_nxt = 1'b1; end
            default:   begin hw_rst_nxt = 1'b0; oe_nxt = 1'b1; ready_nxt = 1'b0; end
        endcase
    end

    // State, counter, strap latch and output registers.
    always_ff @(posedge clk_50) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            // Reset parks the channel in WAIT. An ungated channel steps into
            // RESET on the first active edge, which is what places the start
            // of its reset hold on cycle 0; the drive seen during reset is the
            // same as RESET's.
            state     <= ST_WAIT;
            cnt       <= '0;
            strap_out <= '0;
            strap_oe  <= 1'b1;
            hw_rst    <= 1'b0;
            ready     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            strap_oe <= oe_nxt;
            hw_rst   <= hw_rst_nxt;
            ready    <= ready_nxt;
            if (load_strap) begin
                strap_out <= strap_in;
            end
        end
    end

endmodule

// File: rtl/phy_bringup.sv
// Bring-up sequencer for NUM_PHY Ethernet PHYs: one channel per PHY, optional
// staggered release (each channel gated by its predecessor's ready) and a
// registered all_ready summary.
module phy_bringup
    import phy_bringup_pkg::*;
#(
    parameter int NUM_PHY        = 2,
    parameter int STRAP_W        = 14,
    parameter int RST_HOLD_CYC   = 500000,
    parameter int STRAP_HOLD_CYC = 50,
    parameter int SETTLE_CYC     = 250000,
    parameter int STAGGER        = 0
) (
    input  logic                       clk_50,
    input  logic                       reset_n,
    input  logic [NUM_PHY*STRAP_W-1:0] strap_val,
    input  logic [NUM_PHY-1:0]         reinit_req,
    output logic [NUM_PHY*STRAP_W-1:0] strap_out,
    output logic [NUM_PHY-1:0]         strap_oe,
    output logic [NUM_PHY-1:0]         phy_hw_rst,
    output logic [NUM_PHY-1:0]         phy_ready,
    output logic                       all_ready
);

    logic [NUM_PHY-1:0] gate;

    // Reject a strap width that does not match the packed field layout.
    if (!strap_layout_ok(STRAP_W) || NUM_PHY < 1) begin : g_bad_cfg
        $error("phy_bringup: STRAP_W must be 14 and NUM_PHY at least 1");
    end

    for (genvar i = 0; i < NUM_PHY; i++) begin : g_ch
        // Channel 0, and every channel in parallel mode, starts straight away;
        // in stagger mode channel i waits for channel i-1 to become ready.
        if (i == 0 || STAGGER == 0) begin : g_free
            assign gate[i] = 1'b1;
        end else begin : g_chain
            assign gate[i] = phy_ready[i-1];
        end

        phy_bringup_ch #(
            .STRAP_W        (STRAP_W),
            .RST_HOLD_CYC   (RST_HOLD_CYC),
            .STRAP_HOLD_CYC (STRAP_HOLD_CYC),
            .SETTLE_CYC     (SETTLE_CYC)
        ) u_ch (
            .clk_50    (clk_50),
            .reset_n   (reset_n),
            .gate      (gate[i]),
            .reinit    (reinit_req[i]),
            .strap_in  (strap_val[i*STRAP_W +: STRAP_W]),
            .strap_out (strap_out[i*STRAP_W +: STRAP_W]),
            .strap_oe  (strap_oe[i]),
            .hw_rst    (phy_hw_rst[i]),
            .ready     (phy_ready[i])
        );
    end

    // all_ready is registered, trailing the last channel's ready by one cycle.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            all_ready <= 1'b0;
        end else begin
            all_ready <= &phy_ready;
        end
    end

endmodule

// File: tb/tb_phy_bringup.sv
// Bench for phy_bringup: a parallel and a staggered instance share stimulus;
// a timeline model predicts every output each cycle, and directed literal
// checks pin the model to the documented cycle numbers.
module tb_phy_bringup;

    localparam int N      = 2;
    localparam int SW     = 14;
    localparam int W      = N * SW;
    localparam int RST    = 4;
    localparam int STRAP  = 2;
    localparam int SETTLE = 3;
    localparam int T      = RST + STRAP + SETTLE;

    logic         clk_50 = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] strap_val = '0;
    logic [N-1:0] reinit_req = '0;

    logic [W-1:0] par_strap_out, stg_strap_out;
    logic [N-1:0] par_oe, stg_oe;
    logic [N-1:0] par_hw_rst, stg_hw_rst;
    logic [N-1:0] par_ready, stg_ready;
    logic         par_all, stg_all;

    int cmp_n  = 0;
    int fail_n = 0;
    int cyc    = -1;   // cycles since the first edge with reset_n high
    int edge_n = 0;    // free-running edge count used by the model

    always #10 clk_50 = ~clk_50;

    phy_bringup #(
        .NUM_PHY(N), .STRAP_W(SW), .RST_HOLD_CYC(RST),
        .STRAP_HOLD_CYC(STRAP), .SETTLE_CYC(SETTLE), .STAGGER(0)
    ) dut_par (
        .clk_50(clk_50), .reset_n(reset_n), .strap_val(strap_val),
        .reinit_req(reinit_req), .strap_out(par_strap_out), .strap_oe(par_oe),
        .phy_hw_rst(par_hw_rst), .phy_ready(par_ready), .all_ready(par_all)
    );

    phy_bringup #(
        .NUM_PHY(N), .STRAP_W(SW), .RST_HOLD_CYC(RST),
        .STRAP_HOLD_CYC(STRAP), .SETTLE_CYC(SETTLE), .STAGGER(1)
    ) dut_stg (
        .clk_50(clk_50), .reset_n(reset_n), .strap_val(strap_val),
        .reinit_req(reinit_req), .strap_out(stg_strap_out), .strap_oe(stg_oe),
        .phy_hw_rst(stg_hw_rst), .phy_ready(stg_ready), .all_ready(stg_all)
    );

    always @(posedge clk_50) begin
        edge_n <= edge_n + 1;
        if (!reset_n) cyc <= -1;
        else          cyc <= cyc + 1;
    end

    // ---------------- timeline model ----------------
    // Index 0 = parallel instance, 1 = staggered instance. Each channel is
    // described by whether it has started and the edge it last (re)entered
    // its reset hold; every output follows from the elapsed cycle count.
    bit           model_valid = 1'b0;
    bit           started   [2][N];
    int           start_at  [2][N];
    logic [N-1:0] exp_hw    [2];
    logic [N-1:0] exp_oe    [2];
    logic [N-1:0] exp_rdy   [2];
    logic         exp_all   [2];
    logic [W-1:0] exp_strap [2];

    function automatic bit gate_of(input int p, input int i);
        if (p == 0 || i == 0) return 1'b1;
        return exp_rdy[p][i-1];
    endfunction

    function automatic bit new_started(input int p, input int i);
        return started[p][i] || gate_of(p, i);
    endfunction

    function automatic int new_start(input int p, input int i);
        if (!started[p][i] && gate_of(p, i)) return edge_n;
        if (started[p][i] && reinit_req[i])  return edge_n;
        return start_at[p][i];
    endfunction

    always @(posedge clk_50) begin
        if (!reset_n) begin
            model_valid <= 1'b1;
            for (int p = 0; p < 2; p++) begin
                exp_hw[p]    <= '0;
                exp_oe[p]    <= '1;
                exp_rdy[p]   <= '0;
                exp_all[p]   <= 1'b0;
                exp_strap[p] <= '0;
                for (int i = 0; i < N; i++) started[p][i] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < N; i++) begin
                    // Straps track the input while the PHY is held in reset.
                    if (!exp_hw[p][i])
                        exp_strap[p][i*SW +: SW] <= strap_val[i*SW +: SW];
                    started[p][i]  <= new_started(p, i);
                    start_at[p][i] <= new_start(p, i);
                    exp_hw[p][i]   <= new_started(p, i) && (edge_n - new_start(p, i) >= RST);
                    exp_oe[p][i]   <= !new_started(p, i) || (edge_n - new_start(p, i) < RST + STRAP);
                    exp_rdy[p][i]  <= new_started(p, i) && (edge_n - new_start(p, i) >= T);
                end
                exp_all[p] <= &exp_rdy[p];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_50) begin
        if (model_valid) begin
            check("par.strap_out", 64'(par_strap_out), 64'(exp_strap[0]));
            check("par.strap_oe",  64'(par_oe),        64'(exp_oe[0]));
            check("par.hw_rst",    64'(par_hw_rst),    64'(exp_hw[0]));
            check("par.ready",     64'(par_ready),     64'(exp_rdy[0]));
            check("par.all_ready", 64'(par_all),       64'(exp_all[0]));
            check("stg.strap_out", 64'(stg_strap_out), 64'(exp_strap[1]));
            check("stg.strap_oe",  64'(stg_oe),        64'(exp_oe[1]));
            check("stg.hw_rst",    64'(stg_hw_rst),    64'(exp_hw[1]));
            check("stg.ready",     64'(stg_ready),     64'(exp_rdy[1]));
            check("stg.all_ready", 64'(stg_all),       64'(exp_all[1]));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check_reset_values(input string tag);
        check({tag, ".par.hw_rst"},    64'(par_hw_rst),    64'(0));
        check({tag, ".par.oe"},        64'(par_oe),        64'(2'b11));
        check({tag, ".par.strap_out"}, 64'(par_strap_out), 64'(0));
        check({tag, ".par.ready"},     64'(par_ready),     64'(0));
        check({tag, ".par.all"},       64'(par_all),       64'(0));
        check({tag, ".stg.hw_rst"},    64'(stg_hw_rst),    64'(0));
        check({tag, ".stg.oe"},        64'(stg_oe),        64'(2'b11));
        check({tag, ".stg.ready"},     64'(stg_ready),     64'(0));
        check({tag, ".stg.all"},       64'(stg_all),       64'(0));
    endtask

    // Hold reset for a few edges, check reset drive, release so the next
    // rising edge is cycle 0.
    task automatic apply_reset(input string tag, input logic [W-1:0] straps);
        @(negedge clk_50);
        reset_n    = 1'b0;
        reinit_req = '0;
        strap_val  = straps;
        repeat (3) @(negedge clk_50);
        check_reset_values(tag);
        reset_n = 1'b1;
    endtask

    task automatic wait_cycle(input int c);
        int guard;
        guard = 0;
        do begin
            @(negedge clk_50);
            guard++;
        end while (cyc != c && guard < 2000);
        if (cyc != c) begin
            cmp_n++;
            fail_n++;
            $display("FAIL wait_cycle: reached cyc %0d, want %0d", cyc, c);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] straps_a;
    int           hold [N];

    initial begin
        straps_a = {14'h1F00, 14'h2A55};

        // Parallel bring-up, strap freeze and staggered bring-up.
        apply_reset("rst1", straps_a);
        wait_cycle(0);
        check("bring.strap_c0", 64'(par_strap_out), 64'(straps_a));
        check("bring.oe_c0",    64'(par_oe),        64'(2'b11));
        wait_cycle(3);
        check("bring.hw_c3",    64'(par_hw_rst),    64'(2'b00));
        wait_cycle(4);
        check("bring.hw_c4",    64'(par_hw_rst),    64'(2'b11));
        wait_cycle(5);
        check("bring.oe_c5",    64'(par_oe),        64'(2'b11));
        strap_val[13:0] = 14'h0001;
        wait_cycle(6);
        check("bring.oe_c6",    64'(par_oe),        64'(2'b00));
        check("freeze.ch0",     64'(par_strap_out[13:0]), 64'(14'h2A55));
        check("stg.oe_c6",      64'(stg_oe),        64'(2'b10));
        wait_cycle(8);
        check("bring.rdy_c8",   64'(par_ready),     64'(2'b00));
        wait_cycle(9);
        check("bring.rdy_c9",   64'(par_ready),     64'(2'b11));
        check("bring.all_c9",   64'(par_all),       64'(0));
        check("stg.hw_c9",      64'(stg_hw_rst),    64'(2'b01));
        check("stg.oe_c9",      64'(stg_oe),        64'(2'b10));
        wait_cycle(10);
        check("bring.all_c10",  64'(par_all),       64'(1));
        check("stg.hw_c10",     64'(stg_hw_rst),    64'(2'b01));
        wait_cycle(14);
        check("stg.hw_c14",     64'(stg_hw_rst),    64'(2'b11));
        wait_cycle(18);
        check("stg.rdy_c18",    64'(stg_ready),     64'(2'b01));
        wait_cycle(19);
        check("stg.rdy_c19",    64'(stg_ready),     64'(2'b11));
        check("stg.all_c19",    64'(stg_all),       64'(0));
        wait_cycle(20);
        check("stg.all_c20",    64'(stg_all),       64'(1));
        check("freeze.ch0_c20", 64'(par_strap_out[13:0]), 64'(14'h2A55));

        // One-cycle re-init of channel 1 once everything is up.
        apply_reset("rst2", straps_a);
        wait_cycle(15);
        reinit_req = 2'b10;
        wait_cycle(16);
        reinit_req = 2'b00;
        check("reinit1.rdy_c16", 64'(par_ready),  64'(2'b01));
        check("reinit1.hw_c16",  64'(par_hw_rst), 64'(2'b01));
        check("reinit1.all_c16", 64'(par_all),    64'(1));
        wait_cycle(17);
        check("reinit1.all_c17", 64'(par_all),    64'(0));
        wait_cycle(24);
        check("reinit1.rdy_c24", 64'(par_ready),  64'(2'b01));
        wait_cycle(25);
        check("reinit1.rdy_c25", 64'(par_ready),  64'(2'b11));
        check("reinit1.stg_c25", 64'(stg_ready),  64'(2'b11));
        wait_cycle(26);
        check("reinit1.all_c26", 64'(par_all),    64'(1));

        // Re-init of channel 0 while it is in STRAP.
        apply_reset("rst3", straps_a);
        wait_cycle(5);
        reinit_req = 2'b01;
        wait_cycle(6);
        reinit_req = 2'b00;
        check("reinit0.hw_c6",   64'(par_hw_rst), 64'(2'b10));
        check("reinit0.oe_c6",   64'(par_oe),     64'(2'b01));
        wait_cycle(9);
        check("reinit0.rdy_c9",  64'(par_ready),  64'(2'b10));
        wait_cycle(14);
        check("reinit0.rdy_c14", 64'(par_ready),  64'(2'b10));
        wait_cycle(15);
        check("reinit0.rdy_c15", 64'(par_ready),  64'(2'b11));
        wait_cycle(24);
        check("reinit0.stg_c24", 64'(stg_ready),  64'(2'b01));
        wait_cycle(25);
        check("reinit0.stg_c25", 64'(stg_ready),  64'(2'b11));

        // Reset dropped mid-sequence.
        apply_reset("rst4", straps_a);
        wait_cycle(7);
        reset_n = 1'b0;
        @(negedge clk_50);
        check_reset_values("midrst");

        // Randomised traffic: strap churn, short/held re-init requests and
        // occasional resets, all checked by the model every cycle.
        apply_reset("rst5", W'($urandom));
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk_50);
            for (int i = 0; i < N; i++) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    reinit_req[i] = 1'b1;
                end else if ($urandom_range(0, 39) == 0) begin
                    hold[i] = $urandom_range(0, 3);
                    reinit_req[i] = 1'b1;
                end else begin
                    reinit_req[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 5) == 0) strap_val = W'($urandom);
            if (!reset_n)                             reset_n = 1'b1;
            else if ($urandom_range(0, 299) == 0)     reset_n = 1'b0;
        end
        reinit_req = '0;
        reset_n    = 1'b1;
        repeat (40) @(negedge clk_50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
